// File: rtl/mdu_responder_pkg.sv
// Shared types for the multiply/divide unit: command encoding, FSM states
// and the quotient value loaded when a DIVU has a zero divisor.
package mdu_types;

  typedef enum logic [1:0] {
    MDU_NONE  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIVU  = 2'b10
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } mdu_state_t;

  localparam int MDU_MAX_WIDTH = 64;
  localparam logic [MDU_MAX_WIDTH-1:0] DIV0_LO = '1;

endpackage

// File: rtl/mdu_responder_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and keep the trial difference only if it did not go negative.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   next_rem,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted = {rem, dividend_msb};
    diff    = shifted - {2'b00, divisor};
    q_bit   = ~diff[WIDTH+1];
    // diff[WIDTH+1] is the borrow: restore the shifted value on underflow
    next_rem = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/mdu_responder.sv
// Bit-serial MULTU/DIVU unit owning HI/LO. Define MDU_EARLY_TERM_EN to let
// MULTU finish as soon as the remaining multiplier bits are all zero.
module mdu_responder
  import mdu_types::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  mdu_state_t         state_reg, state_next;
  logic [CW-1:0]      cnt_reg;
  logic [WIDTH-1:0]   a_reg, b_reg, opnd_reg;
  logic [2*WIDTH-1:0] acc_reg, acc_next, product;
  logic [WIDTH:0]     rem_reg, rem_next, mul_sum;
  logic [WIDTH-1:0]   quot_next, hi_reg, lo_reg;
  logic               dz_reg, q_bit, last_step, mul_finish;
  logic               start_mul, start_div, start_div0;

  assign start_mul  = start && (op == MDU_MULTU);
  assign start_div  = start && (op == MDU_DIVU) && (b != '0);
  assign start_div0 = start && (op == MDU_DIVU) && (b == '0);
  assign last_step  = (cnt_reg == CW'(WIDTH - 1));

  // opnd_reg holds the multiplier (shifted right) or the dividend/quotient (shifted left)
  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, (opnd_reg[0] ? a_reg : '0)};
  assign acc_next = {mul_sum, acc_reg[WIDTH-1:1]};

`ifdef MDU_EARLY_TERM_EN
  assign mul_finish = last_step || (opnd_reg[WIDTH-1:1] == '0);
  assign product    = acc_next >> (CW'(WIDTH - 1) - cnt_reg);
`else
  assign mul_finish = last_step;
  assign product    = acc_next;
`endif

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem          (rem_reg),
    .dividend_msb (opnd_reg[WIDTH-1]),
    .divisor      (b_reg),
    .next_rem     (rem_next),
    .q_bit        (q_bit)
  );
  assign quot_next = {opnd_reg[WIDTH-2:0], q_bit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_mul)       state_next = MUL;
        else if (start_div)  state_next = DIV;
        else if (start_div0) state_next = DONE;
      end
      MUL:     if (mul_finish) state_next = DONE;
      DIV:     if (last_step)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_reg != IDLE);
    done        = (state_reg == DONE);
    div_by_zero = (state_reg == DONE) && dz_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      opnd_reg <= '0;
      acc_reg  <= '0;
      rem_reg  <= '0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      dz_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_mul || start_div) begin
            a_reg    <= a;
            b_reg    <= b;
            opnd_reg <= start_mul ? b : a;
            acc_reg  <= '0;
            rem_reg  <= '0;
            cnt_reg  <= '0;
            dz_reg   <= 1'b0;
          end else if (start_div0) begin
            hi_reg <= a;
            lo_reg <= DIV0_LO[WIDTH-1:0];
            dz_reg <= 1'b1;
          end
        end
        MUL: begin
          acc_reg  <= acc_next;
          opnd_reg <= opnd_reg >> 1;
          cnt_reg  <= cnt_reg + CW'(1);
          if (mul_finish) begin
            hi_reg <= product[2*WIDTH-1:WIDTH];
            lo_reg <= product[WIDTH-1:0];
          end
        end
        DIV: begin
          rem_reg  <= rem_next;
          opnd_reg <= quot_next;
          cnt_reg  <= cnt_reg + CW'(1);
          if (last_step) begin
            hi_reg <= rem_next[WIDTH-1:0];
            lo_reg <= quot_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi = hi_reg;
  assign lo = lo_reg;

endmodule

// File: doc/mdu_responder.md
Name: mdu_responder

Overview:
- Multi-cycle multiply/divide unit that executes the MULTU and DIVU operations issued by the control unit, and owns the HI/LO registers.
- The datapath issues a one-cycle start with operands. The unit iterates bit-serially, then pulses done.
- MFHI/MFLO read hi/lo directly. The datapath stalls while busy is high.

Parameters:
- WIDTH, 32, operand and HI/LO register width; must be ≥ 2.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  command strobe, sampled only when busy=0
- op  input  2  mdu_op_t: 2'b01 MULTU, 2'b10 DIVU; other codes invalid
- a  input  WIDTH  multiplicand / dividend (rs)
- b  input  WIDTH  multiplier / divisor (rt)
- busy  output  1  high while state != IDLE
- done  output  1  one-cycle pulse; hi/lo are valid in this cycle
- div_by_zero  output  1  pulses with done when DIVU had b=0
- hi  output  WIDTH  HI register (product upper half / remainder)
- lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (async, active-high): state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, iteration counter=0.
- States: IDLE, MUL, DIV, DONE. busy=1 in MUL, DIV and DONE. done=1 only in DONE.
- IDLE transitions:
  - start=1 with op=MULTU: latch a and b, clear the WIDTH*2 accumulator, counter=0, go to MUL.
  - start=1 with op=DIVU and b!=0: latch a and b, clear the remainder, counter=0, go to DIV.
  - start=1 with op=DIVU and b=0: go directly to DONE. On that edge load hi=a, lo={WIDTH{1'b1}}, and set the div_by_zero flag.
  - start=1 with an invalid op: ignored; stay in IDLE, hi/lo untouched.
- MUL: one shift-add step per cycle (LSB-first multiplier). Unsigned product, 2*WIDTH bits, no overflow. After WIDTH steps go to DONE and load hi={product[2W-1:W]}, lo=product[W-1:0] on that edge.
- DIV: one restoring step per cycle (MSB-first dividend). Remainder register is WIDTH+1 bits so the trial subtract never wraps. After WIDTH steps go to DONE with lo=quotient, hi=remainder.
- DONE: lasts exactly one cycle, then IDLE. start is ignored in DONE because busy is still high.
- Latency: start sampled at edge 0 → done high in cycle WIDTH+1 (DIVU with b=0: cycle 1). A new start is accepted the cycle after done.
- hi/lo change only on the edge entering DONE. They hold their value through all other states, so MFHI/MFLO read stable data during a new operation.
- start held high continuously: a new operation is accepted on every IDLE cycle (back-to-back with a 1-cycle gap).
- Reset mid-operation aborts immediately. hi/lo return to 0 and no done pulse is produced.
- Operands are latched at start. Changes on a/b while busy=1 have no effect.

Optional Feature:
- Macro MDU_EARLY_TERM_EN.
- When defined: in MUL, if the remaining unshifted multiplier bits are all zero, the state machine finishes on the next edge. The accumulator is realigned (shifted by the remaining count) before loading hi/lo. MULTU latency becomes (index of highest set bit of b)+2 cycles, with a minimum of 2 (b=0 or b=1).
- When not defined: MULTU always takes WIDTH+1 cycles.
- DIVU timing is identical in both builds. Results are bit-identical in both builds.

Decomposition:
- Package mdu_types (alongside control_signals) holds:
  - typedef enum logic [1:0] mdu_op_t {MDU_NONE, MDU_MULTU, MDU_DIVU}
  - typedef enum logic [1:0] mdu_state_t {IDLE, MUL, DIV, DONE}
  - localparam DIV0_LO = all-ones
- control_unit maps FUNCT_MULTU/FUNCT_DIVU onto mdu_op_t from this package.
- One natural sub-module: mdu_div_step. It is a combinational single restoring-division step: (rem, dividend_msb, divisor) → (next_rem, q_bit). It is instantiated once.

Test Plan:
- MULTU a=32'hFFFF_FFFF, b=32'hFFFF_FFFF → done at cycle 33; hi=32'hFFFF_FFFE, lo=32'h0000_0001; busy high cycles 1–33.
- DIVU a=100, b=7 → done at cycle 33; lo=14, hi=2, div_by_zero=0. Then DIVU a=5, b=9 → lo=0, hi=5.
- DIVU a=32'h1234_5678, b=0 → done and div_by_zero high at cycle 1; hi=32'h1234_5678, lo=32'hFFFF_FFFF.
- Start with op=2'b11, and start pulsed during MUL and during DONE → no state change, no done pulse, hi/lo unchanged; the in-flight result completes correctly.
- Reset asserted at cycle 10 of MULTU 3×5 → busy=0, hi=lo=0 immediately, no done pulse. A subsequent MULTU 3×5 gives lo=15, hi=0.
- With MDU_EARLY_TERM_EN: MULTU a=1000, b=3 → done at cycle 3, lo=3000. Without the macro, the same stimulus → done at cycle 33, lo=3000.
